// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction queue between the instruction cache and the dual-issue decode
// stage. Each cycle the cache may deliver one or two 32-bit instructions,
// tagged with the fetch PC. Decode sees the two oldest instructions and
// consumes 0, 1 or 2 of them per cycle. A pipeline flush empties the queue.
//
// Ports
//   clk              clock
//   rstn             asynchronous active-low reset
//   flush            pipeline flush; empties the queue on the next edge
//   in_valid         cache data valid this cycle
//   in_pc            PC of in_inst[31:0] (word aligned)
//   in_inst          [31:0] instruction at in_pc, [63:32] at in_pc+4
//   in_second_valid  in_inst[63:32] carries a valid instruction
//   in_ready         at least two free entries; fetch may issue
//   out_valid0/1     slot0 / slot1 hold a valid instruction
//   out_pc0/1        PC of oldest / second-oldest entry
//   out_inst0/1      oldest / second-oldest instruction
//   out_pop          instructions consumed by decode this cycle (0..2)
//   count            current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [63:0]      in_inst,
  input  logic             in_second_valid,
  output logic             in_ready,
  output logic             out_valid0,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_inst0,
  output logic             out_valid1,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst1,
  input  logic [1:0]       out_pop,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Largest occupancy at which two more entries still fit.
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr_p1;
  logic [PTR_W-1:0] rptr_p1;

  logic             push_req;
  logic             push_ok;
  logic             overpop;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;

  assign wptr_p1 = wptr + PTR_W'(1);
  assign rptr_p1 = rptr + PTR_W'(1);

  // Readiness looks only at registered occupancy so fetch never sees a
  // combinational path from decode's pop decision.
  assign in_ready = (count <= READY_MAX);

  assign push_req = in_valid && !flush;
  // A push without in_ready is a protocol violation and is dropped whole.
  assign push_ok  = push_req && in_ready;
  assign overpop  = ((PTR_W+1)'(out_pop) > count);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    push_n = 2'd0;
    pop_n  = out_pop;
    if (push_ok) begin
      push_n = in_second_valid ? 2'd2 : 2'd1;
    end
    // Clamp to what is actually held; pre-push occupancy, so a freshly
    // written entry can never be consumed in the same cycle.
    if (overpop) begin
      pop_n = count[1:0];
    end
    if (flush) begin
      pop_n = 2'd0;
    end
  end

  // NOTE: the entry array carries no reset; occupancy alone decides which
  // entries are meaningful, which keeps the storage a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= '{pc: in_pc, inst: in_inst[31:0]};
      if (in_second_valid) begin
        // wptr_p1 wraps modulo DEPTH, so a pair straddling the end is split.
        mem[wptr_p1] <= '{pc: in_pc + 32'd4, inst: in_inst[63:32]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(push_n);
      rptr  <= rptr + PTR_W'(pop_n);
      count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

  // Outputs come from registered state only: no in_* to out_* path, and a
  // reset clears the valid bits without waiting for a clock edge.
  assign out_valid0 = (count != '0);
  assign out_valid1 = (count > (PTR_W+1)'(1));
  assign out_pc0    = mem[rptr].pc;
  assign out_inst0  = mem[rptr].inst;
  assign out_pc1    = mem[rptr_p1].pc;
  assign out_inst1  = mem[rptr_p1].inst;

  // Protocol monitors: the offending action is already neutralised above,
  // these only make the misuse visible.
  a_push_when_not_ready : assert property (
    @(posedge clk) disable iff (!rstn) !(push_req && !in_ready))
    else $warning("inst_fetch_queue: push while not ready, write dropped");

  a_overpop : assert property (
    @(posedge clk) disable iff (!rstn) !(overpop && !flush))
    else $warning("inst_fetch_queue: pop exceeds occupancy, clamped");

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (DEPTH=8). Each task drives one scenario
// and compares outputs against hand-derived values one time unit after the
// rising edge. Instruction words are a fixed function of their PC so every
// slot can be checked for both fields.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic        in_second_valid;
  logic        in_ready;
  logic        out_valid0;
  logic [31:0] out_pc0;
  logic [31:0] out_inst0;
  logic        out_valid1;
  logic [31:0] out_pc1;
  logic [31:0] out_inst1;
  logic [1:0]  out_pop;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_second_valid (in_second_valid),
    .in_ready        (in_ready),
    .out_valid0      (out_valid0),
    .out_pc0         (out_pc0),
    .out_inst0       (out_inst0),
    .out_valid1      (out_valid1),
    .out_pc1         (out_pc1),
    .out_inst1       (out_inst1),
    .out_pop         (out_pop),
    .count           (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  // ---- stimulus helpers (drive only, no checking) ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_second_valid = 1'b0; out_pop = 2'd0;
    in_pc = 32'h0; in_inst = 64'h0;
  endtask

  task automatic set_push2(input logic [31:0] pc);
    in_valid = 1'b1; in_pc = pc; in_second_valid = 1'b1;
    in_inst = {ins(pc + 32'd4), ins(pc)};
  endtask

  // Upper half carries junk that must never be stored.
  task automatic set_push1(input logic [31:0] pc);
    in_valid = 1'b1; in_pc = pc; in_second_valid = 1'b0;
    in_inst = {32'hFFFF_FFFF, ins(pc)};
  endtask

  task automatic do_push2(input logic [31:0] pc);
    set_push2(pc); tick(); idle();
  endtask

  task automatic do_push1(input logic [31:0] pc);
    set_push1(pc); tick(); idle();
  endtask

  task automatic do_pop(input logic [1:0] n);
    out_pop = n; tick(); idle();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rstn = 1'b0; idle();
    tick(); tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b expected 00", out_valid0, out_valid1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_dual_push();
    in_valid = 1'b1; in_pc = 32'h1C00_0000; in_second_valid = 1'b1;
    in_inst = 64'h0000_0002_0000_0001;
    #1;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL no_bypass: got valid0=%b expected 0", out_valid0); end
    tick(); idle();
    checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin errors++; $display("FAIL dual_valid: got %b%b expected 11", out_valid0, out_valid1); end
    checks++; if (out_pc0 !== 32'h1C00_0000 || out_inst0 !== 32'h1) begin errors++; $display("FAIL dual_slot0: got %h/%h expected 1c000000/00000001", out_pc0, out_inst0); end
    checks++; if (out_pc1 !== 32'h1C00_0004 || out_inst1 !== 32'h2) begin errors++; $display("FAIL dual_slot1: got %h/%h expected 1c000004/00000002", out_pc1, out_inst1); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL dual_count: got %0d expected 2", count); end
    do_pop(2'd2);
    checks++; if (count !== 4'd0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL dual_drain: got count=%0d valid0=%b expected 0/0", count, out_valid0); end
  endtask

  task automatic test_single_push();
    do_push1(32'h1C00_000C);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL single_valid: got %b%b expected 10", out_valid0, out_valid1); end
    checks++; if (out_pc0 !== 32'h1C00_000C || out_inst0 !== ins(32'h1C00_000C)) begin errors++; $display("FAIL single_slot0: got %h/%h expected 1c00000c/%h", out_pc0, out_inst0, ins(32'h1C00_000C)); end
    do_pop(2'd1);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_drain: got %0d expected 0", count); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_cnt [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
    logic       exp_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_push2(32'h2000 + 32'(8 * k));
      checks++; if (count !== exp_cnt[k] || in_ready !== exp_rdy[k]) begin errors++; $display("FAIL fill_%0d: got count=%0d ready=%b expected %0d/%b", k, count, in_ready, exp_cnt[k], exp_rdy[k]); end
    end
    checks++; if (out_pc0 !== 32'h2000 || out_inst1 !== ins(32'h2004)) begin errors++; $display("FAIL fill_head: got %h/%h expected 00002000/%h", out_pc0, out_inst1, ins(32'h2004)); end
    do_pop(2'd2);
    checks++; if (count !== 4'd6 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_pop: got count=%0d ready=%b expected 6/1", count, in_ready); end
    checks++; if (out_pc0 !== 32'h2008 || out_pc1 !== 32'h200C) begin errors++; $display("FAIL fill_order: got %h/%h expected 00002008/0000200c", out_pc0, out_pc1); end
    do_pop(2'd2); do_pop(2'd2); do_pop(2'd2);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL fill_drain: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; tick(); idle();
    for (int k = 0; k < 4; k++) do_push2(32'h1000 + 32'(8 * k));
    do_pop(2'd2);                     // count 6, rptr 2, wptr 0
    set_push2(32'h100); out_pop = 2'd2; tick(); idle();
    checks++; if (count !== 4'd6 || out_pc0 !== 32'h1010 || out_pc1 !== 32'h1014) begin errors++; $display("FAIL wrap_push: got count=%0d pc0=%h pc1=%h expected 6/00001010/00001014", count, out_pc0, out_pc1); end
    do_pop(2'd2); do_pop(2'd1);       // rptr 7: slot1 reads entry 0
    checks++; if (out_pc0 !== 32'h101C || out_pc1 !== 32'h100 || out_inst1 !== ins(32'h100)) begin errors++; $display("FAIL wrap_read: got %h %h/%h expected 0000101c 00000100/%h", out_pc0, out_pc1, out_inst1, ins(32'h100)); end
    do_pop(2'd1);
    checks++; if (count !== 4'd2 || out_pc0 !== 32'h100 || out_inst1 !== ins(32'h104)) begin errors++; $display("FAIL wrap_tail: got count=%0d %h/%h expected 2 00000100/%h", count, out_pc0, out_inst1, ins(32'h104)); end
    do_pop(2'd2);                     // empty, pointers at 2
    do_push2(32'h200); do_push2(32'h208); do_push1(32'h210);
    do_push2(32'h300);                // straddles entry 7 -> entry 0
    checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin errors++; $display("FAIL straddle_count: got count=%0d ready=%b expected 7/0", count, in_ready); end
    do_pop(2'd2); do_pop(2'd2);
    checks++; if (out_pc0 !== 32'h210 || out_pc1 !== 32'h300 || out_inst1 !== ins(32'h300)) begin errors++; $display("FAIL straddle_lo: got %h %h/%h expected 00000210 00000300/%h", out_pc0, out_pc1, out_inst1, ins(32'h300)); end
    do_pop(2'd2);
    checks++; if (count !== 4'd1 || out_pc0 !== 32'h304 || out_inst0 !== ins(32'h304) || out_valid1 !== 1'b0) begin errors++; $display("FAIL straddle_hi: got count=%0d %h/%h v1=%b expected 1 00000304/%h 0", count, out_pc0, out_inst0, out_valid1, ins(32'h304)); end
    do_pop(2'd2);                     // over-pop, clamped to 1
    checks++; if (count !== 4'd0 || out_valid0 !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL overpop: got count=%0d v0=%b ready=%b expected 0/0/1", count, out_valid0, in_ready); end
    do_push2(32'h400);                // rptr must have advanced by exactly 1
    checks++; if (out_pc0 !== 32'h400 || out_pc1 !== 32'h404) begin errors++; $display("FAIL overpop_ptr: got %h/%h expected 00000400/00000404", out_pc0, out_pc1); end
    do_pop(2'd2);
  endtask

  task automatic test_simultaneous();
    do_push2(32'h500); do_push1(32'h508);
    checks++; if (count !== 4'd3 || out_pc1 !== 32'h504) begin errors++; $display("FAIL simul_pre: got count=%0d pc1=%h expected 3/00000504", count, out_pc1); end
    set_push2(32'h600); out_pop = 2'd1; tick(); idle();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL simul_count: got %0d expected 4", count); end
    checks++; if (out_pc0 !== 32'h504 || out_pc1 !== 32'h508 || out_inst1 !== ins(32'h508)) begin errors++; $display("FAIL simul_order: got %h %h/%h expected 00000504 00000508/%h", out_pc0, out_pc1, out_inst1, ins(32'h508)); end
    do_pop(2'd2);
    checks++; if (out_pc0 !== 32'h600 || out_pc1 !== 32'h604) begin errors++; $display("FAIL simul_new: got %h/%h expected 00000600/00000604", out_pc0, out_pc1); end
    do_pop(2'd2);
  endtask

  task automatic test_flush();
    do_push2(32'h700); do_push2(32'h708); do_push1(32'h710);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", count); end
    set_push2(32'h800); out_pop = 2'd2; flush = 1'b1; tick(); idle();
    checks++; if (count !== 4'd0 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got count=%0d v=%b%b ready=%b expected 0/00/1", count, out_valid0, out_valid1, in_ready); end
    tick();
    checks++; if (count !== 4'd0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL flush_nopush: got count=%0d v0=%b expected 0/0", count, out_valid0); end
    do_push2(32'h900);
    checks++; if (count !== 4'd2 || out_pc0 !== 32'h900 || out_inst1 !== ins(32'h904)) begin errors++; $display("FAIL flush_after: got count=%0d %h/%h expected 2 00000900/%h", count, out_pc0, out_inst1, ins(32'h904)); end
  endtask

  task automatic test_async_reset();
    // Queue holds two entries here; drop reset between clock edges.
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got v=%b%b count=%0d ready=%b expected 00/0/1", out_valid0, out_valid1, count, in_ready); end
    tick();
    rstn = 1'b1;
    tick();
    do_push1(32'hA00);
    checks++; if (count !== 4'd1 || out_pc0 !== 32'hA00 || out_valid1 !== 1'b0) begin errors++; $display("FAIL post_reset: got count=%0d pc0=%h v1=%b expected 1/00000a00/0", count, out_pc0, out_valid1); end
  endtask

  initial begin
    test_reset();
    test_dual_push();
    test_single_push();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
